dpr_port_arbiter: RTL
=====================

Name: dpr_port_arbiter

Overview:
- Shares the 4096 x 64 dual-port RAM between two requesters, M0 and M1.
- Writes from either requester are steered to the RAM write port; reads are steered to the RAM read port. Each port has its own round-robin arbiter.
- Read data is returned to the requester that issued the read, tracked by an in-flight tag pipeline.
- Sits between the two client blocks and the RAM. The RAM-side signals map one-to-one onto the RAM's write-enable, read-enable, address and data pins.

Parameters:
- DATA_WIDTH, 64, RAM word width.
- ADDR_WIDTH, 12, RAM address width (4096 words).
- RD_LATENCY, 1, cycles from RAM read-enable sample to valid RAM read data (range 1..4).

Ports:
- clk  in  1  single clock, all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- m0_req  in  1  M0 request, held until granted.
- m0_we  in  1  M0 request type: 1 = write, 0 = read.
- m0_addr  in  ADDR_WIDTH  M0 address.
- m0_wdata  in  DATA_WIDTH  M0 write data.
- m0_gnt  out  1  M0 request accepted this cycle.
- m0_rvalid  out  1  M0 read data valid.
- m0_rdata  out  DATA_WIDTH  M0 read data.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: identical to M0, for M1.
- ram_we_enable  out  1  RAM write enable.
- ram_wr_address  out  ADDR_WIDTH  RAM write address.
- ram_data_in  out  DATA_WIDTH  RAM write data.
- ram_re_enable  out  1  RAM read enable.
- ram_rd_address  out  ADDR_WIDTH  RAM read address.
- ram_data_out  in  DATA_WIDTH  RAM read data.

Behaviour:
- Reset state:
  - All registered outputs clear to 0.
  - mX_gnt is forced to 0 while rst_n is low.
  - Both round-robin pointers point at M0, i.e. M0 wins the first contention on each port.
- Handshake:
  - A requester holds req/we/addr/wdata stable until it sees gnt.
  - mX_gnt is combinational from the current inputs and the arbiter state. Acceptance occurs in the cycle where req && gnt.
- Port split:
  - A write candidate is req && we; a read candidate is req && !we.
  - One write and one read can both be granted in the same cycle, one to each master.
- Round-robin, per port:
  - When both masters are candidates for the same port, the master not granted last on that port wins.
  - The pointer updates only when a grant on that port occurs. A lone candidate is always granted (subject to the hazard rule below).
- RAM drive:
  - A request accepted in cycle N is presented on the ram_* outputs, registered, in cycle N+1.
  - ram_we_enable and ram_re_enable are high for exactly one cycle per accepted request.
- Read return:
  - A tag pipeline RD_LATENCY+1 deep carries {valid, master id}.
  - mX_rvalid goes high in cycle N+1+RD_LATENCY for one cycle.
  - mX_rdata equals ram_data_out in that cycle and holds its last value otherwise.
  - Back-to-back reads at 1 per cycle are supported. Returns come back in issue order.
- RAW hazard:
  - Applies when the write being granted this cycle and a read candidate have equal addresses.
  - The read is not granted that cycle (its gnt stays low) and is granted the next cycle at the earliest. The read therefore always returns the newly written data.
  - The read-port pointer does not advance on the stall.
- Reset mid-operation:
  - In-flight reads are discarded; no rvalid is produced for them after rst_n deasserts.
  - A pending (not yet granted) request is re-arbitrated from the reset pointer state.
- Address wrap: none. Addresses pass through unmodified (0 and 4095 are legal).

Optional Feature:
- Macro: DPR_RW_BYPASS_EN.
- Defined:
  - The RAW hazard read is granted in the same cycle as the write, with no stall.
  - The tag pipeline carries a bypass flag plus the write data.
  - At return, mX_rdata is the forwarded write data instead of ram_data_out.
  - ram_re_enable is still pulsed, keeping RAM timing uniform.
- Not defined: the stall rule above applies and there is no bypass storage.

Test Plan:
- Reset sequence, no requests:
  - Stimulus: rst_n low 3 cycles, then high.
  - Response: all gnt, rvalid, ram_we_enable and ram_re_enable stay 0; rdata = 0.
- Single write then read:
  - Stimulus: M0 writes 64'hDEAD_BEEF_0000_0001 to addr 12'h005, then reads 12'h005.
  - Response: ram_we_enable high one cycle after the write gnt. m0_rvalid appears 2 cycles after the read gnt (RD_LATENCY = 1) with the same data.
- Write contention:
  - Stimulus: M0 and M1 both hold writes, to 12'h010 and 12'h020.
  - Response: cycle 0 grants M0 and cycle 1 grants M1. RAM sees address 010 and then 020.
- Mixed and back-to-back reads:
  - Stimulus: M0 reads 12'h000 while M1 writes 12'hFFF in the same cycle, then M0 and M1 both read on the next 4 cycles.
  - Response: both first requests are granted together. Read grants alternate M1/M0 (M0 was last granted on the read port), and rvalid returns to the correct master in order.
- RAW hazard, same address, old value 64'h1, M1 writes 64'h2 while M0 reads (both 12'h100):
  - Without the macro: M0 gnt is delayed by 1 cycle and m0_rdata = 64'h2.
  - With DPR_RW_BYPASS_EN: M0 is granted in the same cycle and m0_rdata = 64'h2.
- Reset during an in-flight read:
  - Stimulus: assert rst_n low the cycle after a read gnt.
  - Response: no m0_rvalid ever appears for that read. After release the first contention grants M0.

Source files
------------

// File: rtl/dpr_port_arbiter_if.sv
// dpr_port_arbiter_if: client request/return signals and RAM-side pins of the dual-port RAM arbiter
interface dpr_port_arbiter_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 12
);
    logic                  m0_req, m0_we, m0_gnt, m0_rvalid;
    logic [ADDR_WIDTH-1:0] m0_addr;
    logic [DATA_WIDTH-1:0] m0_wdata, m0_rdata;
    logic                  m1_req, m1_we, m1_gnt, m1_rvalid;
    logic [ADDR_WIDTH-1:0] m1_addr;
    logic [DATA_WIDTH-1:0] m1_wdata, m1_rdata;
    logic                  ram_we_enable, ram_re_enable;
    logic [ADDR_WIDTH-1:0] ram_wr_address, ram_rd_address;
    logic [DATA_WIDTH-1:0] ram_data_in, ram_data_out;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m1_req, m1_we, m1_addr, m1_wdata, ram_data_out,
        output m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata,
        output ram_we_enable, ram_re_enable, ram_wr_address, ram_rd_address, ram_data_in
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m1_req, m1_we, m1_addr, m1_wdata, ram_data_out,
        input  m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata,
        input  ram_we_enable, ram_re_enable, ram_wr_address, ram_rd_address, ram_data_in
    );
endinterface

// File: rtl/dpr_port_arbiter.sv
// dpr_port_arbiter: two-master round-robin arbiter onto a dual-port RAM, read data returned by tag.
// Optional DPR_RW_BYPASS_EN: same-address read alongside a write is granted at once and fed the write data.
module dpr_port_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 12,
    parameter int RD_LATENCY = 1
) (
    input logic           clk,
    input logic           rst_n,
    dpr_port_arbiter_if.slave bus
);
    localparam int L = RD_LATENCY;

    logic                  wc0, wc1, rc0, rc1, wg0, wg1, rg0, rg1, hz0, hz1, rv0, rv1;
    logic [ADDR_WIDTH-1:0] waddr, raddr;
    logic [DATA_WIDTH-1:0] wdata, ret_data;
    logic                  wptr_q, wptr_d, rptr_q, rptr_d;
    logic                  ram_we_q, ram_we_d, ram_re_q, ram_re_d;
    logic [ADDR_WIDTH-1:0] ram_wa_q, ram_wa_d, ram_ra_q, ram_ra_d;
    logic [DATA_WIDTH-1:0] ram_wd_q, ram_wd_d;
    logic [L:0]            tv_q, tv_d, tid_q, tid_d;
    logic [DATA_WIDTH-1:0] hold0_q, hold0_d, hold1_q, hold1_d;
`ifdef DPR_RW_BYPASS_EN
    logic [L:0]            byp_q, byp_d;
    logic [DATA_WIDTH-1:0] bd_q [0:L];
    logic [DATA_WIDTH-1:0] bd_d [0:L];
`endif

    // Write port arbitrates first; a read matching the winning write's address is held off unless bypassed
    always_comb begin
        wc0    = bus.m0_req & bus.m0_we;
        wc1    = bus.m1_req & bus.m1_we;
        wg1    = wc1 & (~wc0 | wptr_q);
        wg0    = wc0 & ~wg1;
        waddr  = wg1 ? bus.m1_addr : bus.m0_addr;
        wdata  = wg1 ? bus.m1_wdata : bus.m0_wdata;
        hz0    = (wg0 | wg1) & (bus.m0_addr == waddr);
        hz1    = (wg0 | wg1) & (bus.m1_addr == waddr);
`ifdef DPR_RW_BYPASS_EN
        rc0    = bus.m0_req & ~bus.m0_we;
        rc1    = bus.m1_req & ~bus.m1_we;
`else
        rc0    = bus.m0_req & ~bus.m0_we & ~hz0;
        rc1    = bus.m1_req & ~bus.m1_we & ~hz1;
`endif
        rg1    = rc1 & (~rc0 | rptr_q);
        rg0    = rc0 & ~rg1;
        raddr  = rg1 ? bus.m1_addr : bus.m0_addr;
        wptr_d = wg0 ? 1'b1 : wg1 ? 1'b0 : wptr_q;
        rptr_d = rg0 ? 1'b1 : rg1 ? 1'b0 : rptr_q;
    end

    // Next RAM drive, tag shift and per-master held read data
    always_comb begin
        ram_we_d = wg0 | wg1;
        ram_wa_d = waddr;
        ram_wd_d = wdata;
        ram_re_d = rg0 | rg1;
        ram_ra_d = raddr;
        tv_d     = {tv_q[L-1:0], rg0 | rg1};
        tid_d    = {tid_q[L-1:0], rg1};
        rv0      = tv_q[L] & ~tid_q[L];
        rv1      = tv_q[L] & tid_q[L];
`ifdef DPR_RW_BYPASS_EN
        ret_data = byp_q[L] ? bd_q[L] : bus.ram_data_out;
`else
        ret_data = bus.ram_data_out;
`endif
        hold0_d  = rv0 ? ret_data : hold0_q;
        hold1_d  = rv1 ? ret_data : hold1_q;
    end

    // Arbiter pointers, registered RAM pins, tag pipeline and held read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q   <= 1'b0;
            rptr_q   <= 1'b0;
            ram_we_q <= 1'b0;
            ram_re_q <= 1'b0;
            ram_wa_q <= '0;
            ram_ra_q <= '0;
            ram_wd_q <= '0;
            tv_q     <= '0;
            tid_q    <= '0;
            hold0_q  <= '0;
            hold1_q  <= '0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            ram_we_q <= ram_we_d;
            ram_re_q <= ram_re_d;
            ram_wa_q <= ram_wa_d;
            ram_ra_q <= ram_ra_d;
            ram_wd_q <= ram_wd_d;
            tv_q     <= tv_d;
            tid_q    <= tid_d;
            hold0_q  <= hold0_d;
            hold1_q  <= hold1_d;
        end
    end

`ifdef DPR_RW_BYPASS_EN
    // Bypass flag and the simultaneous write's data travel alongside each read tag
    always_comb begin
        byp_d    = {byp_q[L-1:0], (rg0 & hz0) | (rg1 & hz1)};
        bd_d[0]  = wdata;
        for (int i = 1; i <= L; i++) bd_d[i] = bd_q[i-1];
    end

    // Bypass storage registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byp_q <= '0;
            for (int i = 0; i <= L; i++) bd_q[i] <= '0;
        end else begin
            byp_q <= byp_d;
            bd_q  <= bd_d;
        end
    end
`endif

    assign bus.m0_gnt         = rst_n & (wg0 | rg0);
    assign bus.m1_gnt         = rst_n & (wg1 | rg1);
    assign bus.m0_rvalid      = rv0;
    assign bus.m1_rvalid      = rv1;
    assign bus.m0_rdata       = rv0 ? ret_data : hold0_q;
    assign bus.m1_rdata       = rv1 ? ret_data : hold1_q;
    assign bus.ram_we_enable  = ram_we_q;
    assign bus.ram_wr_address = ram_wa_q;
    assign bus.ram_data_in    = ram_wd_q;
    assign bus.ram_re_enable  = ram_re_q;
    assign bus.ram_rd_address = ram_ra_q;
endmodule
